// File: rtl/rp_pkg.sv
// rtl/rp_pkg.sv - shared axis codes, frame layout, FSM states and helpers for rp_frame_tx
// RP_FRAME_CKSUM_EN extends the frame to 9 bytes with an XOR checksum byte.
package rp_pkg;

  localparam logic [1:0] AXIS_X = 2'd0;
  localparam logic [1:0] AXIS_Y = 2'd1;
  localparam logic [1:0] AXIS_Z = 2'd2;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  localparam int BYTE_HDR = 0;
  localparam int BYTE_SEQ = 1;
  localparam int BYTE_XL  = 2;
  localparam int BYTE_XH  = 3;
  localparam int BYTE_YL  = 4;
  localparam int BYTE_YH  = 5;
  localparam int BYTE_ZL  = 6;
  localparam int BYTE_ZH  = 7;

`ifdef RP_FRAME_CKSUM_EN
  localparam int BYTE_CKSUM  = 8;
  localparam int FRAME_BYTES = 9;
`else
  localparam int FRAME_BYTES = 8;
`endif

  localparam int IDX_W   = $clog2(FRAME_BYTES);
  localparam int FRAME_W = FRAME_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    EMPTY
  } state_e;

  typedef struct packed {
    logic [15:0] z;
    logic [15:0] y;
    logic [15:0] x;
  } axes_t;

`ifdef RP_FRAME_CKSUM_EN
  // Covers seq through ZH; the constant header is deliberately left out.
  function automatic logic [7:0] frame_cksum(input axes_t a, input logic [7:0] seq);
    return seq ^ a.x[7:0] ^ a.x[15:8] ^ a.y[7:0] ^ a.y[15:8] ^ a.z[7:0] ^ a.z[15:8];
  endfunction
`endif

endpackage

// File: rtl/rp_sync_edge.sv
// rtl/rp_sync_edge.sv - N-stage synchroniser for one async input with rise/fall pulses
// Pulses are one CLK wide and come from the last stage against its delayed copy.
module rp_sync_edge #(
  parameter int   N    = 2,
  parameter logic INIT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [N-1:0] sync_q;
  logic         last_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {N{INIT}};
      last_q <= INIT;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      last_q <= sync_q[N-1];
    end
  end

  assign rise_o = sync_q[N-1] & ~last_q;
  assign fall_o = ~sync_q[N-1] & last_q;

endmodule

// File: rtl/rp_frame_tx.sv
// rtl/rp_frame_tx.sv - 3-axis frame collector, pending/shadow double buffer and Pi byte serialiser
// Define RP_FRAME_CKSUM_EN to append an XOR checksum byte to each frame.
module rp_frame_tx
  import rp_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] HEADER      = HEADER_DEFAULT
) (
  input  logic        CLK_50,
  input  logic        RST,
  input  logic        sample_valid,
  input  logic [1:0]  sample_axis,
  input  logic [15:0] sample_data,
  input  logic        rp_clk,
  input  logic        rp_cs_n,
  output logic [7:0]  rp_data,
  output logic        rp_data_oe,
  output logic        frame_ready,
  output logic [7:0]  ovf_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  logic clk_rise, cs_rise, cs_fall;
  logic rp_clk_fall_unused;

  rp_sync_edge #(.N(SYNC_STAGES), .INIT(1'b0)) u_sync_clk (
    .clk_i  (CLK_50),
    .rst_i  (RST),
    .d_i    (rp_clk),
    .rise_o (clk_rise),
    .fall_o (rp_clk_fall_unused)
  );

  // chip-select idles high, so its synchroniser resets high to avoid a false assert
  rp_sync_edge #(.N(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
    .clk_i  (CLK_50),
    .rst_i  (RST),
    .d_i    (rp_cs_n),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 sent_q, sent_d;
  axes_t                col_q, col_d;
  logic [2:0]           mask_q, mask_d;
  axes_t                pend_q, pend_d;
  logic                 pend_full_q, pend_full_d;
  logic [FRAME_W-1:0]   shadow_q, shadow_d;
  logic [7:0]           seq_q, seq_d;
  logic                 frame_ready_q, frame_ready_d;
  logic [7:0]           ovf_q, ovf_d;
  logic [7:0]           data_q, data_d;
  logic                 oe_q, oe_d;
  logic                 complete, promote, clear_ready;

  always_comb begin
    col_d    = col_q;
    mask_d   = mask_q;
    complete = 1'b0;
    if (sample_valid) begin
      case (sample_axis)
        AXIS_X: begin col_d.x = sample_data; mask_d[0] = 1'b1; end
        AXIS_Y: begin col_d.y = sample_data; mask_d[1] = 1'b1; end
        AXIS_Z: begin col_d.z = sample_data; mask_d[2] = 1'b1; end
        default: ;
      endcase
    end
    if (mask_d == 3'b111) begin
      complete = 1'b1;
      mask_d   = 3'b000;
    end
  end

  // Promotion reads the old pending contents, so a frame completing in the same
  // cycle can safely land in pending without counting as an overwrite.
  assign promote = (state_q == IDLE) && pend_full_q && !frame_ready_q;

  always_comb begin
    pend_d        = pend_q;
    pend_full_d   = pend_full_q;
    ovf_d         = ovf_q;
    shadow_d      = shadow_q;
    seq_d         = seq_q;
    frame_ready_d = frame_ready_q;
    if (promote) begin
      pend_full_d                   = 1'b0;
      shadow_d[BYTE_HDR*8 +: 8]     = HEADER;
      shadow_d[BYTE_SEQ*8 +: 8]     = seq_q;
      shadow_d[BYTE_XL*8 +: 8]      = pend_q.x[7:0];
      shadow_d[BYTE_XH*8 +: 8]      = pend_q.x[15:8];
      shadow_d[BYTE_YL*8 +: 8]      = pend_q.y[7:0];
      shadow_d[BYTE_YH*8 +: 8]      = pend_q.y[15:8];
      shadow_d[BYTE_ZL*8 +: 8]      = pend_q.z[7:0];
      shadow_d[BYTE_ZH*8 +: 8]      = pend_q.z[15:8];
`ifdef RP_FRAME_CKSUM_EN
      shadow_d[BYTE_CKSUM*8 +: 8]   = frame_cksum(pend_q, seq_q);
`endif
      seq_d                         = seq_q + 8'd1;
      frame_ready_d                 = 1'b1;
    end
    if (complete) begin
      pend_d      = col_d;
      pend_full_d = 1'b1;
      if (pend_full_q && !promote && (ovf_q != 8'hFF)) begin
        ovf_d = ovf_q + 8'd1;
      end
    end
    if (clear_ready) begin
      frame_ready_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sent_d      = sent_q;
    clear_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          if (frame_ready_q) begin
            state_d = SEND;
            idx_d   = '0;
            sent_d  = 1'b0;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      SEND: begin
        // CS release wins over a coincident strobe; an unfinished read keeps the frame.
        if (cs_rise) begin
          clear_ready = sent_q;
          state_d     = IDLE;
        end else if (clk_rise && !sent_q) begin
          if (idx_q == LAST_IDX) begin
            sent_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      EMPTY: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = 8'h00;
    oe_d   = (state_q != IDLE);
    if ((state_q == SEND) && !sent_q) begin
      data_d = shadow_q[{idx_q, 3'b000} +: 8];
    end
  end

  always_ff @(posedge CLK_50) begin
    if (RST) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      sent_q        <= 1'b0;
      col_q         <= '0;
      mask_q        <= 3'b000;
      pend_q        <= '0;
      pend_full_q   <= 1'b0;
      shadow_q      <= '0;
      seq_q         <= 8'h00;
      frame_ready_q <= 1'b0;
      ovf_q         <= 8'h00;
      data_q        <= 8'h00;
      oe_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sent_q        <= sent_d;
      col_q         <= col_d;
      mask_q        <= mask_d;
      pend_q        <= pend_d;
      pend_full_q   <= pend_full_d;
      shadow_q      <= shadow_d;
      seq_q         <= seq_d;
      frame_ready_q <= frame_ready_d;
      ovf_q         <= ovf_d;
      data_q        <= data_d;
      oe_q          <= oe_d;
    end
  end

  assign rp_data     = data_q;
  assign rp_data_oe  = oe_q;
  assign frame_ready = frame_ready_q;
  assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_rp_frame_tx.sv
// tb/tb_rp_frame_tx.sv - self-checking bench for rp_frame_tx against a transaction-level frame model
module tb_rp_frame_tx;

`ifdef RP_FRAME_CKSUM_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [1:0]  sample_axis;
  logic [15:0] sample_data;
  logic        rp_clk;
  logic        rp_cs_n;
  logic [7:0]  rp_data;
  logic        rp_data_oe;
  logic        frame_ready;
  logic [7:0]  ovf_cnt;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  rp_frame_tx dut (
    .CLK_50       (clk),
    .RST          (rst),
    .sample_valid (sample_valid),
    .sample_axis  (sample_axis),
    .sample_data  (sample_data),
    .rp_clk       (rp_clk),
    .rp_cs_n      (rp_cs_n),
    .rp_data      (rp_data),
    .rp_data_oe   (rp_data_oe),
    .frame_ready  (frame_ready),
    .ovf_cnt      (ovf_cnt)
  );

  // Frame-level model: collect slots, one pending frame, one shadow frame.
  logic [15:0] m_col [3];
  bit          m_have [3];
  logic [15:0] m_pend [3];
  bit          m_pend_v;
  logic [15:0] m_sh [3];
  logic [7:0]  m_sh_seq;
  logic [7:0]  m_seq;
  bit          m_ready;
  int          m_ovf;

  task automatic m_reset();
    for (int i = 0; i < 3; i++) m_have[i] = 0;
    m_pend_v = 0; m_ready = 0; m_seq = 8'h00; m_ovf = 0;
  endtask

  task automatic m_promote_pend();
    m_sh = m_pend; m_sh_seq = m_seq; m_seq = m_seq + 8'd1; m_ready = 1; m_pend_v = 0;
  endtask

  task automatic m_sample(input int axis, input logic [15:0] data);
    if (axis < 3) begin
      m_col[axis] = data;
      m_have[axis] = 1;
      if (m_have[0] && m_have[1] && m_have[2]) begin
        for (int i = 0; i < 3; i++) m_have[i] = 0;
        if (m_pend_v && m_ovf < 255) m_ovf++;
        m_pend = m_col;
        m_pend_v = 1;
        if (!m_ready) m_promote_pend();
      end
    end
  endtask

  task automatic m_read_done();
    m_ready = 0;
    if (m_pend_v) m_promote_pend();
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] b [9];
    b[0] = 8'hA5;
    b[1] = m_sh_seq;
    for (int a = 0; a < 3; a++) begin
      b[2 + 2*a] = m_sh[a][7:0];
      b[3 + 2*a] = m_sh[a][15:8];
    end
    b[8] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6] ^ b[7];
    return (k < FB) ? b[k] : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_sample(input int axis, input logic [15:0] data);
    @(negedge clk);
    sample_valid = 1'b1; sample_axis = axis[1:0]; sample_data = data;
    @(negedge clk);
    sample_valid = 1'b0;
    m_sample(axis, data);
  endtask

  task automatic send_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    send_sample(0, x); send_sample(1, y); send_sample(2, z);
    idle(4);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_ready"}, frame_ready, m_ready);
    check({tag, "_ovf"}, ovf_cnt, m_ovf[15:0]);
  endtask

  task automatic cs_assert();
    rp_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    check("oe_lat3", rp_data_oe, 1'b0);
    @(negedge clk);
    check("oe_lat4", rp_data_oe, 1'b1);
  endtask

  task automatic cs_release(input bit with_clk);
    if (with_clk) rp_clk = 1'b1;
    rp_cs_n = 1'b1;
    repeat (5) @(negedge clk);
    rp_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("oe_off", rp_data_oe, 1'b0);
  endtask

  task automatic do_read(input int n, input bit with_clk);
    cs_assert();
    for (int i = 0; i < n; i++) begin
      check($sformatf("byte%0d", i), rp_data, exp_byte(i));
      rp_clk = 1'b1;
      if (i == 0) begin
        repeat (3) @(negedge clk);
        check("data_lat3", rp_data, exp_byte(0));
        @(negedge clk);
        check("data_lat4", rp_data, exp_byte(1));
        @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      rp_clk = 1'b0;
      repeat (5) @(negedge clk);
    end
    if (n >= FB) check("after_last", rp_data, 8'h00);
    cs_release(with_clk);
    if (n >= FB && !with_clk) m_read_done();
    check_status("read");
  endtask

  task automatic do_empty_read();
    cs_assert();
    check("empty_data", rp_data, 8'h00);
    rp_clk = 1'b1; repeat (5) @(negedge clk);
    rp_clk = 1'b0; repeat (5) @(negedge clk);
    check("empty_data2", rp_data, 8'h00);
    cs_release(0);
    check_status("empty");
  endtask

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_axis = 2'd0; sample_data = 16'h0;
    rp_clk = 1'b0; rp_cs_n = 1'b1;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_data", rp_data, 8'h00);
    check("rst_oe", rp_data_oe, 1'b0);
    check_status("rst");
    rst = 1'b0;
    idle(3);

    // basic frame
    send_frame(16'h1234, 16'hFFFE, 16'h0001);
    check_status("s1");
    do_read(FB, 0);

    // CS with nothing to send
    do_empty_read();

    // overflow: three frames, no read in between
    send_frame(16'($urandom), 16'($urandom), 16'($urandom));
    send_frame(16'($urandom), 16'($urandom), 16'($urandom));
    check_status("s2_two");
    send_frame(16'($urandom), 16'($urandom), 16'($urandom));
    check_status("s2_three");
    do_read(FB, 0);
    do_read(FB, 0);

    // aborted read then retransmission
    send_frame(16'($urandom), 16'($urandom), 16'($urandom));
    do_read(3, 0);
    do_read(FB, 0);

    // final strobe coincides with CS release: frame must be kept
    send_frame(16'($urandom), 16'($urandom), 16'($urandom));
    do_read(FB - 1, 1);
    do_read(FB, 0);

    // dropped axis and overwritten X
    send_sample(3, 16'hDEAD);
    send_sample(0, 16'h1111);
    send_sample(0, 16'h2222);
    idle(4);
    check_status("s5_x");
    send_sample(1, 16'h8000);
    idle(4);
    check_status("s5_y");
    send_sample(2, 16'h7FFF);
    idle(4);
    check_status("s5_z");
    do_read(FB, 0);

    // randomized traffic
    for (int r = 0; r < 8; r++) begin
      int nsamp;
      int act;
      nsamp = $urandom_range(3, 7);
      for (int s = 0; s < nsamp; s++) send_sample($urandom_range(0, 3), 16'($urandom));
      idle(4);
      check_status("rnd");
      act = $urandom_range(0, 2);
      if (act != 0) begin
        if (m_ready) do_read((act == 1) ? FB : $urandom_range(0, FB - 1), 0);
        else do_empty_read();
      end
    end

    // reset in the middle of a transmission
    if (m_ready) do_read(FB, 0);
    send_frame(16'($urandom), 16'($urandom), 16'($urandom));
    rp_cs_n = 1'b0; idle(6);
    for (int i = 0; i < 2; i++) begin
      rp_clk = 1'b1; idle(5); rp_clk = 1'b0; idle(5);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_oe", rp_data_oe, 1'b0);
    check("rst_mid_ready", frame_ready, 1'b0);
    rp_cs_n = 1'b1;
    idle(3);
    rst = 1'b0;
    m_reset();
    idle(5);
    check("post_rst_data", rp_data, 8'h00);
    check_status("post_rst");
    send_frame(16'h1234, 16'hFFFE, 16'h0001);
    do_read(FB, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
